// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment counter display.
// Segment bit order is bit0=a through bit6=g, active-high.
package seg_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec
  } cnt_op_e;

  function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button to one-cycle press pulse: 2-FF synchroniser, counting debouncer,
// rising-edge detect on the debounced level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_button;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/segment_counter_mux.sv
// N-digit BCD up/down counter on two debounced buttons with a scanned 7-segment output.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module segment_counter_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REFRESH_CYCLES  = 8,
  parameter int unsigned WRAP            = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        button_plus,
  input  logic                        button_minus,
  output logic [6:0]                  segment,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic [BCD_W*NUM_DIGITS-1:0] value_bcd,
  output logic                        wrap_pulse
);

  localparam int unsigned VAL_W = BCD_W * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  logic             w_plus;
  logic             w_minus;
  cnt_op_e          w_op;
  logic [VAL_W-1:0] w_inc_val;
  logic [VAL_W-1:0] w_dec_val;
  logic             w_at_max;
  logic             w_at_zero;
  logic [BCD_W-1:0] w_sel_digit;

  logic [VAL_W-1:0] r_value;
  logic             r_wrap;
  logic [REF_W-1:0] r_ref_cnt;
  logic [IDX_W-1:0] r_digit_idx;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_plus (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_button(button_plus),
    .o_press (w_plus)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_minus (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_button(button_minus),
    .o_press (w_minus)
  );

  // Simultaneous presses cancel.
  always_comb begin
    case ({w_plus, w_minus})
      2'b10:   w_op = CntInc;
      2'b01:   w_op = CntDec;
      default: w_op = CntHold;
    endcase
  end

  // Digit-wise ripple carry/borrow; overflow naturally yields all-0 / all-9.
  always_comb begin : next_value
    logic             carry;
    logic             borrow;
    logic [BCD_W-1:0] dig;
    w_inc_val = r_value;
    w_dec_val = r_value;
    w_at_max  = 1'b1;
    w_at_zero = 1'b1;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = r_value[i*BCD_W +: BCD_W];
      if (dig != 4'd9) w_at_max = 1'b0;
      if (dig != 4'd0) w_at_zero = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          w_inc_val[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          w_inc_val[i*BCD_W +: BCD_W] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          w_dec_val[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          w_dec_val[i*BCD_W +: BCD_W] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (w_op)
        CntInc: begin
          if (!w_at_max) begin
            r_value <= w_inc_val;
          end else if (WRAP != 0) begin
            r_value <= w_inc_val;
            r_wrap  <= 1'b1;
          end
        end
        CntDec: begin
          if (!w_at_zero) begin
            r_value <= w_dec_val;
          end else if (WRAP != 0) begin
            r_value <= w_dec_val;
            r_wrap  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_cnt   <= '0;
      r_digit_idx <= '0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt   <= '0;
      r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  always_comb begin
    w_sel_digit = '0;
    digit_en    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) begin
        w_sel_digit = r_value[i*BCD_W +: BCD_W];
        digit_en[i] = 1'b1;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_upper_nz;

  // Any nonzero digit at or above the selected one keeps it lit.
  always_comb begin
    w_upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) >= r_digit_idx && r_value[i*BCD_W +: BCD_W] != 4'd0) begin
        w_upper_nz = 1'b1;
      end
    end
  end

  assign segment = (r_digit_idx != '0 && !w_upper_nz) ? SEG_BLANK : bcd_to_seg(w_sel_digit);
`else
  assign segment = bcd_to_seg(w_sel_digit);
`endif

  assign value_bcd  = r_value;
  assign wrap_pulse = (WRAP != 0) ? r_wrap : 1'b0;

endmodule

// File: tb/tb_segment_counter_mux.sv
// Scoreboard bench: dut0 is the default 4-digit wrapping counter, dut1 a 2-digit saturating one.
module tb_segment_counter_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0 = 1'b0, m0 = 1'b0, p1 = 1'b0, m1 = 1'b0;
  logic [6:0]  seg0, seg1;
  logic [3:0]  en0;
  logic [1:0]  en1;
  logic [15:0] val0;
  logic [7:0]  val1;
  logic        wrap0, wrap1;

  always #5 clk = ~clk;

  segment_counter_mux #(
    .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(8), .WRAP(1)
  ) dut0 (
    .clk(clk), .rst(rst), .button_plus(p0), .button_minus(m0),
    .segment(seg0), .digit_en(en0), .value_bcd(val0), .wrap_pulse(wrap0)
  );

  segment_counter_mux #(
    .NUM_DIGITS(2), .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(8), .WRAP(0)
  ) dut1 (
    .clk(clk), .rst(rst), .button_plus(p1), .button_minus(m1),
    .segment(seg1), .digit_en(en1), .value_bcd(val1), .wrap_pulse(wrap1)
  );

  typedef struct {
    logic [15:0] val;
    logic        wrap;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          model0 = 0;
  int          model1 = 0;
  int          wraps0 = 0;
  int          wraps1 = 0;
  logic [15:0] prev0 = '0;
  logic [7:0]  prev1 = '0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx, input int n);
    logic [6:0] s;
    s = seg_of(v[idx*4 +: 4]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      bit upper_zero;
      upper_zero = 1'b1;
      for (int j = idx; j < n; j++) if (v[j*4 +: 4] != 4'd0) upper_zero = 1'b0;
      if (idx > 0 && upper_zero) s = 7'h00;
    end
`endif
    return s;
  endfunction

  // Scoreboard monitor: every value change must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev0 = val0;
      prev1 = val1;
    end else begin
      if (wrap0) wraps0++;
      if (wrap1) wraps1++;
      if (val0 !== prev0) begin
        n_checks++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb0_unexpected: value %h appeared, nothing expected", val0);
        end else begin
          e = q0.pop_front();
          if (val0 !== e.val || wrap0 !== e.wrap) begin
            n_fail++;
            $display("FAIL sb0_update: value %h wrap %b, expected %h wrap %b",
                     val0, wrap0, e.val, e.wrap);
          end
        end
      end else if (wrap0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb0_stray_wrap: wrap 1 with value %h unchanged, expected 0", val0);
      end
      if (val1 !== prev1) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_unexpected: value %h appeared, nothing expected", val1);
        end else begin
          e = q1.pop_front();
          if (val1 !== e.val[7:0] || wrap1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sb1_update: value %h wrap %b, expected %h wrap 0",
                     val1, wrap1, e.val[7:0]);
          end
        end
      end
      prev0 = val0;
      prev1 = val1;
    end
  end

  task automatic push0(input int dir);
    logic w;
    w = 1'b0;
    if (dir > 0) begin
      if (model0 == 9999) begin model0 = 0; w = 1'b1; end
      else model0++;
    end else begin
      if (model0 == 0) begin model0 = 9999; w = 1'b1; end
      else model0--;
    end
    q0.push_back('{to_bcd(model0), w});
  endtask

  task automatic push1(input int dir);
    int old;
    old = model1;
    if (dir > 0 && model1 < 99) model1++;
    if (dir < 0 && model1 > 0) model1--;
    if (model1 != old) q1.push_back('{to_bcd(model1), 1'b0});
  endtask

  task automatic press(input int dut, input logic pl, input logic mi, input int hold,
                       input int rel);
    @(negedge clk);
    if (dut == 0) begin p0 = pl; m0 = mi; end
    else begin p1 = pl; m1 = mi; end
    repeat (hold) @(negedge clk);
    p0 = 1'b0; m0 = 1'b0; p1 = 1'b0; m1 = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic step0(input int dir, input int times);
    for (int i = 0; i < times; i++) begin
      push0(dir);
      press(0, dir > 0, dir < 0, 10, 12);
    end
  endtask

  task automatic step1(input int dir, input int times);
    for (int i = 0; i < times; i++) begin
      push1(dir);
      press(1, dir > 0, dir < 0, 10, 12);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL pending_before_reset: %0d/%0d outstanding, expected 0/0",
               q0.size(), q1.size());
    end
    rst = 1'b1;
    p0 = 1'b0; m0 = 1'b0; p1 = 1'b0; m1 = 1'b0;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
    model0 = 0;
    model1 = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (val0 !== 16'h0000 || en0 !== 4'b0001 || seg0 !== 7'b0111111 || wrap0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut0: val %h en %b seg %b wrap %b, expected 0000 0001 0111111 0",
               val0, en0, seg0, wrap0);
    end
    n_checks++;
    if (val1 !== 8'h00 || en1 !== 2'b01 || seg1 !== 7'b0111111 || wrap1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut1: val %h en %b seg %b wrap %b, expected 00 01 0111111 0",
               val1, en1, seg1, wrap1);
    end
  endtask

  task automatic test_scan();
    int idx;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      idx = (k / 8) % 4;
      n_checks++;
      if (en0 !== 4'(1 << idx) || seg0 !== exp_seg(16'h0000, idx, 4)) begin
        n_fail++;
        $display("FAIL scan0 k=%0d: en %b seg %b, expected en %b seg %b",
                 k, en0, seg0, 4'(1 << idx), exp_seg(16'h0000, idx, 4));
      end
      n_checks++;
      if (en1 !== 2'(1 << ((k / 8) % 2))) begin
        n_fail++;
        $display("FAIL scan1 k=%0d: en %b, expected %b", k, en1, 2'(1 << ((k / 8) % 2)));
      end
    end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #8 p0 = 1'b1;
    #5 p0 = 1'b0;
    repeat (3) @(negedge clk);
    p0 = 1'b1;
    repeat (3) @(negedge clk);
    p0 = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (val0 !== 16'h0000) begin
      n_fail++;
      $display("FAIL glitch_ignored: value %h, expected 0000", val0);
    end
  endtask

  task automatic test_press_timing();
    push0(1);
    @(negedge clk);
    p0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        n_checks++;
        if (val0 !== 16'h0000) begin
          n_fail++;
          $display("FAIL press_edge6: value %h, expected 0000", val0);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (val0 !== 16'h0001) begin
          n_fail++;
          $display("FAIL press_edge7: value %h, expected 0001", val0);
        end
      end
    end
    repeat (3) @(negedge clk);
    p0 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_count_seq();
    apply_reset();
    step0(1, 3);
    step0(-1, 1);
    step0(1, 1);
    n_checks++;
    if (val0 !== 16'h0003) begin
      n_fail++;
      $display("FAIL seq_3p1m1p: value %h, expected 0003", val0);
    end
    push0(1);
    press(0, 1'b1, 1'b0, 200, 12);
    n_checks++;
    if (val0 !== 16'h0004) begin
      n_fail++;
      $display("FAIL held_counts_once: value %h, expected 0004", val0);
    end
  endtask

  task automatic test_bcd_carry();
    step0(1, 5);
    n_checks++;
    if (val0 !== 16'h0009) begin
      n_fail++;
      $display("FAIL reach_9: value %h, expected 0009", val0);
    end
    step0(1, 1);
    n_checks++;
    if (val0 !== 16'h0010) begin
      n_fail++;
      $display("FAIL bcd_carry: value %h, expected 0010", val0);
    end
  endtask

  task automatic test_simultaneous();
    int w;
    step0(1, 32);
    n_checks++;
    if (val0 !== 16'h0042) begin
      n_fail++;
      $display("FAIL reach_42: value %h, expected 0042", val0);
    end
    w = wraps0;
    press(0, 1'b1, 1'b1, 10, 12);
    n_checks++;
    if (val0 !== 16'h0042 || wraps0 != w) begin
      n_fail++;
      $display("FAIL both_buttons: value %h wraps +%0d, expected 0042 +0", val0, wraps0 - w);
    end
  endtask

  task automatic test_wrap();
    int w;
    apply_reset();
    w = wraps0;
    step0(-1, 1);
    n_checks++;
    if (val0 !== 16'h9999 || wraps0 != w + 1) begin
      n_fail++;
      $display("FAIL wrap_down: value %h wraps +%0d, expected 9999 +1", val0, wraps0 - w);
    end
    step0(1, 1);
    n_checks++;
    if (val0 !== 16'h0000 || wraps0 != w + 2) begin
      n_fail++;
      $display("FAIL wrap_up: value %h wraps +%0d, expected 0000 +2", val0, wraps0 - w);
    end
  endtask

  task automatic test_saturate();
    step1(1, 99);
    n_checks++;
    if (val1 !== 8'h99) begin
      n_fail++;
      $display("FAIL sat_reach_99: value %h, expected 99", val1);
    end
    step1(1, 1);
    n_checks++;
    if (val1 !== 8'h99) begin
      n_fail++;
      $display("FAIL sat_hold_max: value %h, expected 99", val1);
    end
    apply_reset();
    step1(-1, 1);
    n_checks++;
    if (val1 !== 8'h00 || wraps1 != 0) begin
      n_fail++;
      $display("FAIL sat_hold_zero: value %h wraps %0d, expected 00 0", val1, wraps1);
    end
  endtask

  task automatic test_display();
    logic [3:0] seen;
    int idx;
    step0(1, 7);
    seen = '0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      idx = -1;
      for (int i = 0; i < 4; i++) if (en0 == 4'(1 << i)) idx = i;
      n_checks++;
      if (idx < 0) begin
        n_fail++;
        $display("FAIL disp_onehot: en %b, expected one-hot", en0);
      end else begin
        seen[idx] = 1'b1;
        if (seg0 !== exp_seg(to_bcd(model0), idx, 4)) begin
          n_fail++;
          $display("FAIL disp_digit%0d: seg %b, expected %b",
                   idx, seg0, exp_seg(to_bcd(model0), idx, 4));
        end
      end
    end
    n_checks++;
    if (seen !== 4'hF) begin
      n_fail++;
      $display("FAIL disp_frame: digits seen %b, expected 1111", seen);
    end
  endtask

  task automatic test_reset_mid();
    repeat (11) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (val0 !== 16'h0000 || en0 !== 4'b0001 || seg0 !== 7'b0111111 || wrap0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: val %h en %b seg %b wrap %b, expected 0000 0001 0111111 0",
               val0, en0, seg0, wrap0);
    end
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
    model0 = 0;
    model1 = 0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_press_timing();
    test_count_seq();
    test_bcd_carry();
    test_simultaneous();
    test_wrap();
    test_saturate();
    test_display();
    test_reset_mid();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL pending_at_end: %0d/%0d outstanding, expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
